// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_pkg
// Description : Shared opcode encodings, FSM state type and helper function
//               for the multiply/divide unit (md_unit).
// Revision    : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

  localparam int MD_OP_LEN = 3;

  localparam logic [MD_OP_LEN-1:0] MD_OP_NONE  = 3'd0;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULT  = 3'd1;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULTU = 3'd2;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIV   = 3'd3;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIVU  = 3'd4;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTHI  = 3'd5;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic md_is_muldiv(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit holding the architectural
//               HI/LO registers. The result is computed in the start cycle,
//               parked in pending registers and committed to HI/LO when the
//               latency counter expires.
// Ports       : clk    - clock, all state on posedge
//               reset  - synchronous active-high reset, clears all state
//               start  - qualifies op for one cycle
//               op     - MD_OP_* opcode
//               src0   - rs operand (dividend / MTHI/MTLO data)
//               src1   - rt operand (divisor / multiplier)
//               busy   - operation in flight, or mult/div starting this cycle
//               hi, lo - architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]     src0,
  input  logic [WIDTH-1:0]     src1,
  output logic                 busy,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic             r_pend_we;

  md_state_t        w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic             w_load;
  logic             w_busy;

  // --------------------------------------------------------------------------
  // Result datapath (evaluated on the live operands of the start cycle)
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_pend_hi;
  logic [WIDTH-1:0]   w_pend_lo;
  logic               w_pend_we;

  assign w_prod_u = {{WIDTH{1'b0}}, src0} * {{WIDTH{1'b0}}, src1};
  assign w_prod_s = $signed({{WIDTH{src0[WIDTH-1]}}, src0}) *
                    $signed({{WIDTH{src1[WIDTH-1]}}, src1});

  // Signed divide is done on magnitudes and the signs restored afterwards.
  // This also yields the required -2^(W-1) / -1 result with no special case:
  // the magnitude 2^(W-1) is representable unsigned and is not negated.
  assign w_div_signed = (op == MD_OP_DIV);
  assign w_a_neg      = w_div_signed & src0[WIDTH-1];
  assign w_b_neg      = w_div_signed & src1[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -src0 : src0;
  assign w_b_mag      = w_b_neg ? -src1 : src1;
  assign w_div_zero   = (src1 == '0);
  // Keep the divider free of X when the divisor is zero; result is discarded.
  assign w_b_safe     = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem        = w_a_neg ? -w_r_mag : w_r_mag;

  always_comb begin
    w_pend_hi = w_prod_u[2*WIDTH-1:WIDTH];
    w_pend_lo = w_prod_u[WIDTH-1:0];
    w_pend_we = 1'b1;
    case (op)
      MD_OP_MULT: begin
        w_pend_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_pend_lo = w_prod_s[WIDTH-1:0];
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        w_pend_hi = w_rem;
        w_pend_lo = w_quot;
        w_pend_we = ~w_div_zero;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control: next state, counter, HI/LO writes and busy
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_load     = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_OP_MULT, MD_OP_MULTU: begin
              w_load     = 1'b1;
              w_busy     = 1'b1;
              w_cnt_nx   = CNT_W'(MULT_CYCLES);
              w_state_nx = ST_RUN;
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              w_load     = 1'b1;
              w_busy     = 1'b1;
              w_cnt_nx   = CNT_W'(DIV_CYCLES);
              w_state_nx = ST_RUN;
            end
            MD_OP_MTHI: w_hi_nx = src0;
            MD_OP_MTLO: w_lo_nx = src0;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Any start seen here is dropped; only the countdown advances.
        w_busy   = 1'b1;
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nx = ST_IDLE;
          if (r_pend_we) begin
            w_hi_nx = r_pend_hi;
            w_lo_nx = r_pend_lo;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      if (w_load) begin
        r_pend_hi <= w_pend_hi;
        r_pend_lo <= w_pend_lo;
        r_pend_we <= w_pend_we;
      end
    end
  end

  assign busy = w_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit. Directed scenarios plus a
//               randomized sequence compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  src0;
  logic [W-1:0]  src1;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src0  (src0),
    .src1  (src1),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Architectural model: HI/LO after the given instruction retires.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b);
    longint       sp;
    logic [63:0]  up;
    int           sa;
    int           sb;
    sa = a;
    sb = b;
    case (o)
      MD_OP_MULT: begin
        sp   = longint'(sa) * longint'(sb);
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      MD_OP_MULTU: begin
        up   = {32'h0, a} * {32'h0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      MD_OP_DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = a;
            m_hi = 32'h0;
          end else begin
            m_lo = sa / sb;
            m_hi = sa % sb;
          end
        end
      end
      MD_OP_DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      MD_OP_MTHI: m_hi = a;
      MD_OP_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] o);
    if (o == MD_OP_MULT || o == MD_OP_MULTU) return MC + 1;
    if (o == MD_OP_DIV  || o == MD_OP_DIVU)  return DC + 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and wait (bounded) until the unit is idle again.
  // nb returns the number of cycles busy was observed high.
  task automatic exec(input logic [2:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int nb);
    start = 1'b1;
    op    = o;
    src0  = a;
    src1  = b;
    #1;
    nb = (busy === 1'b1) ? 1 : 0;
    tick();
    start = 1'b0;
    src0  = $urandom;
    src1  = $urandom;
    while (busy === 1'b1 && nb < 60) begin
      nb++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = MD_OP_NONE;
    src0  = '0;
    src1  = '0;
    tick();
    tick();
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  task automatic test_mult_timing();
    int nb;
    exec(MD_OP_MTHI, 32'hAAAA_5555, 32'h0, nb);
    exec(MD_OP_MTLO, 32'h5555_AAAA, 32'h0, nb);
    start = 1'b1;
    op    = MD_OP_MULT;
    src0  = 32'hFFFF_FFFD;
    src1  = 32'd5;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mult_busy_c0: busy=%b required 1", busy);
    end
    tick();
    start = 1'b0;
    src0  = $urandom;
    src1  = $urandom;
    for (int k = 1; k <= MC; k++) begin
      checks++;
      if (busy !== 1'b1 || hi !== 32'hAAAA_5555 || lo !== 32'h5555_AAAA) begin
        failures++;
        $display("FAIL mult_run_c%0d: busy=%b hi=%h lo=%h required busy=1 hi=aaaa5555 lo=5555aaaa",
                 k, busy, hi, lo);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      failures++;
      $display("FAIL mult_commit: busy=%b hi=%h lo=%h required busy=0 hi=ffffffff lo=fffffff1",
               busy, hi, lo);
    end
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFF1;
  endtask

  task automatic test_multu();
    int nb;
    exec(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, nb);
    checks++;
    if (nb != MC + 1 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL multu: busy_cycles=%0d hi=%h lo=%h required %0d 00000001 fffffffe",
               nb, hi, lo, MC + 1);
    end
    exec(MD_OP_MULT, 32'hFFFF_FFFF, 32'd2, nb);
    checks++;
    if (nb != MC + 1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mult_neg1x2: busy_cycles=%0d hi=%h lo=%h required %0d ffffffff fffffffe",
               nb, hi, lo, MC + 1);
    end
    m_hi = hi;
    m_lo = lo;
  endtask

  task automatic test_div();
    int nb;
    exec(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
    checks++;
    if (nb != DC + 1 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_neg7_2: busy_cycles=%0d hi=%h lo=%h required %0d ffffffff fffffffd",
               nb, hi, lo, DC + 1);
    end
    exec(MD_OP_DIVU, 32'd7, 32'd2, nb);
    checks++;
    if (nb != DC + 1 || lo !== 32'd3 || hi !== 32'd1) begin
      failures++;
      $display("FAIL divu_7_2: busy_cycles=%0d hi=%h lo=%h required %0d 1 3", nb, hi, lo, DC + 1);
    end
    exec(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    checks++;
    if (nb != DC + 1 || lo !== 32'h8000_0000 || hi !== 32'h0) begin
      failures++;
      $display("FAIL div_overflow: busy_cycles=%0d hi=%h lo=%h required %0d 0 80000000",
               nb, hi, lo, DC + 1);
    end
    m_hi = 32'h0;
    m_lo = 32'h8000_0000;
  endtask

  task automatic test_mt_divzero();
    int nb0;
    int nb1;
    int nb2;
    exec(MD_OP_MTHI, 32'h1234_5678, $urandom, nb0);
    exec(MD_OP_MTLO, 32'h9ABC_DEF0, $urandom, nb1);
    checks++;
    if (nb0 != 0 || nb1 != 0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      failures++;
      $display("FAIL mthi_mtlo: busy_cycles=%0d/%0d hi=%h lo=%h required 0/0 12345678 9abcdef0",
               nb0, nb1, hi, lo);
    end
    exec(MD_OP_DIVU, $urandom, 32'h0, nb2);
    checks++;
    if (nb2 != DC + 1 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      failures++;
      $display("FAIL divu_by_zero: busy_cycles=%0d hi=%h lo=%h required %0d 12345678 9abcdef0",
               nb2, hi, lo, DC + 1);
    end
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom;
    b = $urandom;
    model(MD_OP_MULT, a, b);
    start = 1'b1;
    op    = MD_OP_MULT;
    src0  = a;
    src1  = b;
    tick();                       // cycle 1
    start = 1'b0;
    tick();                       // cycle 2
    tick();                       // cycle 3
    start = 1'b1;
    op    = MD_OP_MTHI;
    src0  = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL ignore_busy_c3: busy=%b required 1", busy);
    end
    tick();                       // cycle 4
    start = 1'b0;
    tick();                       // cycle 5
    tick();                       // cycle 6
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL ignore_start: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
               busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    int           nb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom;
    b = $urandom;
    model(MD_OP_MULT, a, b);
    exec(MD_OP_MULT, a, b, nb);   // starts in cycle 6 of the previous op
    checks++;
    if (nb != MC + 1 || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL back_to_back: busy_cycles=%0d hi=%h lo=%h required %0d %h %h",
               nb, hi, lo, MC + 1, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    op    = MD_OP_DIV;
    src0  = 32'd100;
    src1  = 32'd7;
    tick();                       // cycle 1
    start = 1'b0;
    tick();
    tick();
    tick();                       // cycle 4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
    for (int k = 0; k < DC + 2; k++) tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int           nb;
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      model(o, a, b);
      exec(o, a, b, nb);
      checks++;
      if (nb != exp_busy(o) || hi !== m_hi || lo !== m_lo) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: busy_cycles=%0d hi=%h lo=%h required %0d %h %h",
                 i, o, a, b, nb, hi, lo, exp_busy(o), m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_multu();
    test_div();
    test_mt_divzero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
